// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU op encodings and the ID/EX register layout for the
// decode-to-execute stage.
package id_ex_stage_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef enum logic [2:0] {
    ALU_ROL = 3'b000,
    ALU_SLL = 3'b001,
    ALU_ROR = 3'b010,
    ALU_SRL = 3'b011,
    ALU_ADD = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_AND = 3'b111
  } alu_op_e;

  // Everything the stage carries from decode; an all-zero value is a bubble.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
    alu_op_e           op;
    logic              inv_a;
    logic              inv_b;
    logic              sign;
    logic              cin;
  } ex_regs_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Priority forward selector: EX/MEM result, then MEM/WB result, then the
// operand value captured from the register file.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [REG_W-1:0]  reg_idx,
  input  logic              exm_reg_write,
  input  logic [REG_W-1:0]  exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_W-1:0]  mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  input  logic [DATA_W-1:0] reg_val,
  output logic [DATA_W-1:0] fwd_val
);

  // EX/MEM holds the younger write, so it wins when both stages match.
  always_comb begin
    fwd_val = reg_val;
    if (exm_reg_write && (exm_rd == reg_idx)) begin
      fwd_val = exm_result;
    end else if (mwb_reg_write && (mwb_rd == reg_idx)) begin
      fwd_val = mwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble
// insertion, stall hold and flush squash.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rs_val,
  input  logic [DATA_W-1:0]     id_rt_val,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  id_use_imm,
  input  logic                  id_use_rt,
  input  logic [REG_W-1:0]      id_rs,
  input  logic [REG_W-1:0]      id_rt,
  input  logic [REG_W-1:0]      id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic [2:0]            id_op,
  input  logic                  id_invA,
  input  logic                  id_invB,
  input  logic                  id_sign,
  input  logic                  id_cin,
  input  logic                  exm_reg_write,
  input  logic [REG_W-1:0]      exm_rd,
  input  logic [DATA_W-1:0]     exm_result,
  input  logic                  mwb_reg_write,
  input  logic [REG_W-1:0]      mwb_rd,
  input  logic [DATA_W-1:0]     mwb_result,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_InA,
  output logic [DATA_W-1:0]     ex_InB,
  output logic [2:0]            ex_Op,
  output logic                  ex_Cin,
  output logic                  ex_invA,
  output logic                  ex_invB,
  output logic                  ex_sign,
  output logic [REG_W-1:0]      ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  load_use_stall
);

  ex_regs_t          stage_q;
  ex_regs_t          stage_d;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  fwd_mux u_fwd_rs (
    .reg_idx       (stage_q.rs),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .reg_val       (stage_q.rs_val),
    .fwd_val       (fwd_rs)
  );

  fwd_mux u_fwd_rt (
    .reg_idx       (stage_q.rt),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .reg_val       (stage_q.rt_val),
    .fwd_val       (fwd_rt)
  );

  assign load_use_stall = stage_q.valid & stage_q.mem_read & stage_q.reg_write & id_valid &
                          ((id_rs == stage_q.rd) | (id_use_rt & (id_rt == stage_q.rd)));

  // While held, operands recapture their forwarded value so a result that
  // is only on a forward bus this cycle is not lost.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (stall) begin
      stage_d.rs_val = fwd_rs;
      stage_d.rt_val = fwd_rt;
    end else if (load_use_stall) begin
      stage_d = '0;
    end else begin
      stage_d.valid     = id_valid;
      stage_d.rs_val    = id_rs_val;
      stage_d.rt_val    = id_rt_val;
      stage_d.imm       = id_imm;
      stage_d.use_imm   = id_use_imm;
      stage_d.rs        = id_rs;
      stage_d.rt        = id_rt;
      stage_d.rd        = id_rd;
      stage_d.reg_write = id_reg_write & id_valid;
      stage_d.mem_read  = id_mem_read & id_valid;
      stage_d.op        = alu_op_e'(id_op);
      stage_d.inv_a     = id_invA;
      stage_d.inv_b     = id_invB;
      stage_d.sign      = id_sign;
      stage_d.cin       = id_cin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ex_valid     = stage_q.valid;
  assign ex_InA       = fwd_rs;
  assign ex_InB       = stage_q.use_imm ? stage_q.imm : fwd_rt;
  assign ex_Op        = stage_q.op;
  assign ex_Cin       = stage_q.cin;
  assign ex_invA      = stage_q.inv_a;
  assign ex_invB      = stage_q.inv_b;
  assign ex_sign      = stage_q.sign;
  assign ex_rd        = stage_q.rd;
  assign ex_reg_write = stage_q.reg_write;
  assign ex_mem_read  = stage_q.mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written stall/reset
// sequence, then random traffic against a behavioural model of the stage.
module tb_id_ex_stage;

  typedef struct {
    logic        rst, stall, flush;
    logic        id_valid;
    logic [15:0] rs_val, rt_val, imm;
    logic        use_imm, use_rt;
    logic [2:0]  rs, rt, rd;
    logic        reg_write, mem_read;
    logic [2:0]  op;
    logic        inv_a, inv_b, sign, cin;
    logic        exm_we;
    logic [2:0]  exm_rd;
    logic [15:0] exm_res;
    logic        mwb_we;
    logic [2:0]  mwb_rd;
    logic [15:0] mwb_res;
  } stim_t;

  typedef struct {
    logic        valid;
    logic [15:0] ina, inb;
    logic [2:0]  op;
    logic        cin, inv_a, inv_b, sign;
    logic [2:0]  rd;
    logic        reg_write, mem_read, lus;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  // Abstract contents of the stage: the decoded instruction it currently holds.
  typedef struct {
    bit          valid;
    logic [15:0] rs_val, rt_val, imm;
    bit          use_imm;
    logic [2:0]  rs, rt, rd;
    bit          reg_write, mem_read;
    logic [2:0]  op;
    bit          inv_a, inv_b, sign, cin;
  } model_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_imm, id_use_rt, id_reg_write, id_mem_read;
  logic [15:0] id_rs_val, id_rt_val, id_imm, exm_result, mwb_result;
  logic [2:0]  id_rs, id_rt, id_rd, id_op, exm_rd, mwb_rd;
  logic        id_invA, id_invB, id_sign, id_cin, exm_reg_write, mwb_reg_write;
  logic        stall, flush;
  logic        ex_valid, ex_Cin, ex_invA, ex_invB, ex_sign, ex_reg_write, ex_mem_read;
  logic        load_use_stall;
  logic [15:0] ex_InA, ex_InB;
  logic [2:0]  ex_Op, ex_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_use_rt(id_use_rt), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_op(id_op), .id_invA(id_invA), .id_invB(id_invB), .id_sign(id_sign), .id_cin(id_cin),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_InA(ex_InA), .ex_InB(ex_InB),
    .ex_Op(ex_Op), .ex_Cin(ex_Cin), .ex_invA(ex_invA), .ex_invB(ex_invB), .ex_sign(ex_sign),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .load_use_stall(load_use_stall)
  );

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t instr(logic v, logic [2:0] rs, logic [15:0] rs_val, logic [2:0] rt,
                                  logic [15:0] rt_val, logic use_rt, logic [15:0] imm,
                                  logic use_imm, logic [2:0] rd, logic rw, logic mr,
                                  logic [2:0] op);
    stim_t s;
    s = idleStim();
    s.id_valid = v; s.rs = rs; s.rs_val = rs_val; s.rt = rt; s.rt_val = rt_val;
    s.use_rt = use_rt; s.imm = imm; s.use_imm = use_imm; s.rd = rd;
    s.reg_write = rw; s.mem_read = mr; s.op = op;
    return s;
  endfunction

  function automatic exp_t mkExp(logic v, logic [15:0] ina, logic [15:0] inb, logic [2:0] op,
                                 logic [2:0] rd, logic rw, logic mr, logic lus);
    exp_t e;
    e = '{default: '0};
    e.valid = v; e.ina = ina; e.inb = inb; e.op = op; e.rd = rd;
    e.reg_write = rw; e.mem_read = mr; e.lus = lus;
    return e;
  endfunction

  // Newest producer first: EX/MEM, then MEM/WB, else the captured value.
  function automatic logic [15:0] modelFwd(logic [2:0] idx, logic [15:0] own, stim_t s);
    logic        we  [2];
    logic [2:0]  rd  [2];
    logic [15:0] res [2];
    we[0] = s.exm_we; rd[0] = s.exm_rd; res[0] = s.exm_res;
    we[1] = s.mwb_we; rd[1] = s.mwb_rd; res[1] = s.mwb_res;
    for (int k = 0; k < 2; k++) begin
      if (we[k] && rd[k] == idx) return res[k];
    end
    return own;
  endfunction

  function automatic bit modelHazard(model_t m, stim_t s);
    bit load_in_ex;
    bit reads_it;
    load_in_ex = m.valid && m.mem_read && m.reg_write;
    reads_it   = (s.rs == m.rd) || (s.use_rt && s.rt == m.rd);
    return load_in_ex && s.id_valid && reads_it;
  endfunction

  function automatic exp_t modelExpect(model_t m, stim_t s);
    exp_t e;
    e.valid = m.valid;
    e.ina = modelFwd(m.rs, m.rs_val, s);
    e.inb = m.use_imm ? m.imm : modelFwd(m.rt, m.rt_val, s);
    e.op = m.op; e.cin = m.cin; e.inv_a = m.inv_a; e.inv_b = m.inv_b; e.sign = m.sign;
    e.rd = m.rd; e.reg_write = m.reg_write; e.mem_read = m.mem_read;
    e.lus = modelHazard(m, s);
    return e;
  endfunction

  function automatic model_t modelNext(model_t m, stim_t s);
    model_t n;
    model_t empty;
    empty = '{default: '0};
    n = m;
    if (s.rst || s.flush) begin
      n = empty;
    end else if (s.stall) begin
      n.rs_val = modelFwd(m.rs, m.rs_val, s);
      n.rt_val = modelFwd(m.rt, m.rt_val, s);
    end else if (modelHazard(m, s)) begin
      n = empty;
    end else begin
      n.valid = s.id_valid; n.rs_val = s.rs_val; n.rt_val = s.rt_val; n.imm = s.imm;
      n.use_imm = s.use_imm; n.rs = s.rs; n.rt = s.rt; n.rd = s.rd;
      n.reg_write = s.reg_write && s.id_valid; n.mem_read = s.mem_read && s.id_valid;
      n.op = s.op; n.inv_a = s.inv_a; n.inv_b = s.inv_b; n.sign = s.sign; n.cin = s.cin;
    end
    return n;
  endfunction

  task automatic applyStimulus(input stim_t s);
    rst = s.rst; stall = s.stall; flush = s.flush;
    id_valid = s.id_valid; id_rs_val = s.rs_val; id_rt_val = s.rt_val; id_imm = s.imm;
    id_use_imm = s.use_imm; id_use_rt = s.use_rt; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
    id_reg_write = s.reg_write; id_mem_read = s.mem_read; id_op = s.op;
    id_invA = s.inv_a; id_invB = s.inv_b; id_sign = s.sign; id_cin = s.cin;
    exm_reg_write = s.exm_we; exm_rd = s.exm_rd; exm_result = s.exm_res;
    mwb_reg_write = s.mwb_we; mwb_rd = s.mwb_rd; mwb_result = s.mwb_res;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic checkAll(input string tag, input exp_t e);
    checkOutput({tag, ".ex_valid"},       16'(ex_valid),       16'(e.valid));
    checkOutput({tag, ".ex_InA"},         ex_InA,              e.ina);
    checkOutput({tag, ".ex_InB"},         ex_InB,              e.inb);
    checkOutput({tag, ".ex_Op"},          16'(ex_Op),          16'(e.op));
    checkOutput({tag, ".ex_Cin"},         16'(ex_Cin),         16'(e.cin));
    checkOutput({tag, ".ex_invA"},        16'(ex_invA),        16'(e.inv_a));
    checkOutput({tag, ".ex_invB"},        16'(ex_invB),        16'(e.inv_b));
    checkOutput({tag, ".ex_sign"},        16'(ex_sign),        16'(e.sign));
    checkOutput({tag, ".ex_rd"},          16'(ex_rd),          16'(e.rd));
    checkOutput({tag, ".ex_reg_write"},   16'(ex_reg_write),   16'(e.reg_write));
    checkOutput({tag, ".ex_mem_read"},    16'(ex_mem_read),    16'(e.mem_read));
    checkOutput({tag, ".load_use_stall"}, 16'(load_use_stall), 16'(e.lus));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t randomStim();
    stim_t s;
    s.rst = ($urandom_range(0, 99) < 3); s.flush = ($urandom_range(0, 99) < 10);
    s.stall = ($urandom_range(0, 99) < 20); s.id_valid = ($urandom_range(0, 99) < 80);
    s.rs_val = 16'($urandom); s.rt_val = 16'($urandom); s.imm = 16'($urandom);
    s.use_imm = 1'($urandom); s.use_rt = 1'($urandom);
    s.rs = 3'($urandom_range(0, 3)); s.rt = 3'($urandom_range(0, 3)); s.rd = 3'($urandom_range(0, 3));
    s.reg_write = ($urandom_range(0, 99) < 75); s.mem_read = ($urandom_range(0, 99) < 40);
    s.op = 3'($urandom); s.inv_a = 1'($urandom); s.inv_b = 1'($urandom);
    s.sign = 1'($urandom); s.cin = 1'($urandom);
    s.exm_we = 1'($urandom); s.exm_rd = 3'($urandom_range(0, 3)); s.exm_res = 16'($urandom);
    s.mwb_we = 1'($urandom); s.mwb_rd = 3'($urandom_range(0, 3)); s.mwb_res = 16'($urandom);
    return s;
  endfunction

  initial begin
    vec_t   vec [17];
    stim_t  s_alu, s_r2, s_load, s_dep, s_imm, s_gate, s_keep, s_junk, s;
    exp_t   e;
    model_t m;

    s_alu  = instr(1, 3'd1, 16'h1234, 3'd2, 16'h0001, 1, 16'h0000, 0, 3'd5, 1, 0, 3'b100);
    s_r2   = instr(1, 3'd2, 16'h1111, 3'd0, 16'h2222, 1, 16'h0000, 0, 3'd1, 1, 0, 3'b001);
    s_r2.cin = 1'b1; s_r2.inv_a = 1'b1;
    s_load = instr(1, 3'd0, 16'h0010, 3'd0, 16'h0000, 0, 16'h0004, 1, 3'd3, 1, 1, 3'b000);
    s_dep  = instr(1, 3'd3, 16'h0BAD, 3'd4, 16'h0007, 1, 16'h0000, 0, 3'd6, 1, 0, 3'b100);
    s_imm  = instr(1, 3'd6, 16'h0303, 3'd5, 16'h1111, 1, 16'hFFF0, 1, 3'd7, 1, 0, 3'b010);
    s_imm.sign = 1'b1; s_imm.inv_b = 1'b1;
    s_gate = instr(0, 3'd0, 16'h0000, 3'd0, 16'h0000, 0, 16'h0000, 0, 3'd4, 1, 1, 3'b011);

    // Each row: inputs driven this cycle and the outputs expected before the edge.
    vec[0].s = idleStim();  vec[0].e = mkExp(0, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0);
    vec[1].s = s_alu;       vec[1].e = mkExp(0, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0);
    vec[2].s = idleStim();  vec[2].e = mkExp(1, 16'h1234, 16'h0001, 3'b100, 3'd5, 1, 0, 0);
    vec[3].s = s_r2;        vec[3].e = mkExp(0, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0);
    vec[4].s = s_r2;
    vec[4].s.exm_we = 1; vec[4].s.exm_rd = 3'd2; vec[4].s.exm_res = 16'hAAAA;
    vec[4].s.mwb_we = 1; vec[4].s.mwb_rd = 3'd2; vec[4].s.mwb_res = 16'h5555;
    vec[4].e = mkExp(1, 16'hAAAA, 16'h2222, 3'b001, 3'd1, 1, 0, 0);
    vec[4].e.cin = 1; vec[4].e.inv_a = 1;
    vec[5].s = s_r2;
    vec[5].s.mwb_we = 1; vec[5].s.mwb_rd = 3'd2; vec[5].s.mwb_res = 16'h5555;
    vec[5].e = mkExp(1, 16'h5555, 16'h2222, 3'b001, 3'd1, 1, 0, 0);
    vec[5].e.cin = 1; vec[5].e.inv_a = 1;
    vec[6].s = s_load;
    vec[6].e = mkExp(1, 16'h1111, 16'h2222, 3'b001, 3'd1, 1, 0, 0);
    vec[6].e.cin = 1; vec[6].e.inv_a = 1;
    vec[7].s = s_dep;       vec[7].e = mkExp(1, 16'h0010, 16'h0004, 3'd0, 3'd3, 1, 1, 1);
    vec[8].s = s_dep;       vec[8].e = mkExp(0, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0);
    vec[9].s = idleStim();
    vec[9].s.mwb_we = 1; vec[9].s.mwb_rd = 3'd3; vec[9].s.mwb_res = 16'hBEEF;
    vec[9].e = mkExp(1, 16'hBEEF, 16'h0007, 3'b100, 3'd6, 1, 0, 0);
    vec[10].s = s_load;     vec[10].e = mkExp(0, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0);
    vec[11].s = s_dep;      vec[11].s.flush = 1;
    vec[11].e = mkExp(1, 16'h0010, 16'h0004, 3'd0, 3'd3, 1, 1, 1);
    vec[12].s = idleStim(); vec[12].e = mkExp(0, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0);
    vec[13].s = s_imm;      vec[13].e = mkExp(0, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0);
    vec[14].s = idleStim();
    vec[14].s.exm_we = 1; vec[14].s.exm_rd = 3'd5; vec[14].s.exm_res = 16'hDEAD;
    vec[14].e = mkExp(1, 16'h0303, 16'hFFF0, 3'b010, 3'd7, 1, 0, 0);
    vec[14].e.sign = 1; vec[14].e.inv_b = 1;
    vec[15].s = s_gate;     vec[15].e = mkExp(0, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0);
    vec[16].s = idleStim(); vec[16].e = mkExp(0, 16'h0000, 16'h0000, 3'b011, 3'd4, 0, 0, 0);

    s = idleStim();
    s.rst = 1;
    applyStimulus(s);
    nextCycle();
    nextCycle();

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vec[i].s);
      #2;
      checkAll($sformatf("vec%0d", i), vec[i].e);
      nextCycle();
    end

    // Three-cycle stall with a one-cycle forward, then reset while still stalled.
    s_keep = instr(1, 3'd1, 16'h0101, 3'd2, 16'h0202, 1, 16'h0000, 0, 3'd2, 1, 0, 3'b101);
    s_junk = instr(1, 3'd7, 16'hFFFF, 3'd7, 16'hFFFF, 1, 16'hFFFF, 0, 3'd7, 1, 1, 3'b111);
    s_junk.stall = 1;
    applyStimulus(s_keep);
    nextCycle();
    s = s_junk;
    s.exm_we = 1; s.exm_rd = 3'd1; s.exm_res = 16'h0F0F;
    applyStimulus(s);
    #2;
    checkAll("stall1", mkExp(1, 16'h0F0F, 16'h0202, 3'b101, 3'd2, 1, 0, 0));
    nextCycle();
    for (int i = 2; i <= 3; i++) begin
      applyStimulus(s_junk);
      #2;
      checkAll($sformatf("stall%0d", i), mkExp(1, 16'h0F0F, 16'h0202, 3'b101, 3'd2, 1, 0, 0));
      nextCycle();
    end
    s = s_junk;
    s.rst = 1;
    applyStimulus(s);
    nextCycle();
    applyStimulus(idleStim());
    #2;
    checkAll("rst_in_stall", mkExp(0, 16'h0000, 16'h0000, 3'd0, 3'd0, 0, 0, 0));
    nextCycle();

    m = '{default: '0};
    for (int i = 0; i < 400; i++) begin
      s = randomStim();
      if (i == 0) s.rst = 1;
      applyStimulus(s);
      #2;
      if (i > 0) begin
        e = modelExpect(m, s);
        checkAll($sformatf("rand%0d", i), e);
      end
      m = modelNext(m, s);
      nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
